// File: rtl/cpu_controller_if.sv
// Control bus between the accumulator-CPU controller and its datapath.
interface cpu_controller_if;
    logic [7:0] instrCU;
    logic       zeroCU;
    logic       weCU;
    logic       buffIRCU;
    logic       buffAHCU;
    logic       buffALCU;
    logic       buffRCU;
    logic       srcbmuxCU;
    logic       adrmuxCU;
    logic [1:0] acmuxCU;
    logic [1:0] pcmuxCU;
    logic [2:0] aluopCU;
    logic       halted;

    // Controller side: consumes IR and ALU zero, drives every strobe/select.
    modport master (
        input  instrCU, zeroCU,
        output weCU, buffIRCU, buffAHCU, buffALCU, buffRCU,
               srcbmuxCU, adrmuxCU, acmuxCU, pcmuxCU, aluopCU, halted
    );

    // Datapath side.
    modport slave (
        output instrCU, zeroCU,
        input  weCU, buffIRCU, buffAHCU, buffALCU, buffRCU,
               srcbmuxCU, adrmuxCU, acmuxCU, pcmuxCU, aluopCU, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle Moore controller for the 8-bit accumulator CPU: fetch, decode,
// two-byte address fetch, memory access and HALT, with an internal Z flag.
module cpu_controller (
    input  logic             clk,
    input  logic             reset,
    cpu_controller_if.master io_bus
);
    localparam logic [7:0] OP_LDAC = 8'h01;
    localparam logic [7:0] OP_STAC = 8'h02;
    localparam logic [7:0] OP_MVAC = 8'h03;
    localparam logic [7:0] OP_MOVR = 8'h04;
    localparam logic [7:0] OP_JUMP = 8'h05;
    localparam logic [7:0] OP_JMPZ = 8'h06;
    localparam logic [7:0] OP_JPNZ = 8'h07;
    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_INAC = 8'h0A;
    localparam logic [7:0] OP_CLAC = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NOT  = 8'h0F;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_ADRH   = 3'd2,
        S_ADRL   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_z;

    logic [7:0] w_instr;
    logic       w_is_alu;
    logic       w_is_mem;
    logic       w_is_three;
    logic       w_jump_taken;

    logic       w_we, w_ir, w_ah, w_al, w_r, w_srcb, w_adr, w_halted;
    logic [1:0] w_acmux, w_pcmux;
    logic [2:0] w_aluop;

    assign w_instr      = io_bus.instrCU;
    assign w_is_alu     = (w_instr[7:3] == 5'b00001);
    assign w_is_mem     = (w_instr == OP_LDAC) || (w_instr == OP_STAC);
    assign w_is_three   = w_is_mem || (w_instr == OP_JUMP) ||
                          (w_instr == OP_JMPZ) || (w_instr == OP_JPNZ);
    assign w_jump_taken = (w_instr == OP_JUMP) ||
                          ((w_instr == OP_JMPZ) &&  r_z) ||
                          ((w_instr == OP_JPNZ) && !r_z);

    // State sequencing and Z flag capture at the end of DECODE for ALU ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_is_alu)
                        r_z <= io_bus.zeroCU;
                    if (w_instr == OP_HALT)
                        r_state <= S_HALT;
                    else if (w_is_three)
                        r_state <= S_ADRH;
                    else
                        r_state <= S_FETCH;
                end
                S_ADRH:   r_state <= S_ADRL;
                S_ADRL:   r_state <= w_is_mem ? S_MEM : S_FETCH;
                S_MEM:    r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Control decode; the datapath samples these only at the next rising
    // edge, so they are left combinational and forced idle during reset.
    always_comb begin
        w_we     = 1'b0;
        w_ir     = 1'b0;
        w_ah     = 1'b0;
        w_al     = 1'b0;
        w_r      = 1'b0;
        w_srcb   = 1'b0;
        w_adr    = 1'b0;
        w_acmux  = 2'b00;
        w_pcmux  = 2'b00;
        w_aluop  = 3'b000;
        w_halted = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    w_ir    = 1'b1;
                    w_pcmux = 2'b01;
                end
                S_DECODE: begin
                    case (w_instr)
                        OP_MVAC: w_r     = 1'b1;
                        OP_MOVR: w_acmux = 2'b10;
                        OP_ADD:  w_aluop = 3'b001;
                        OP_SUB:  w_aluop = 3'b010;
                        OP_INAC: begin
                            w_aluop = 3'b001;
                            w_srcb  = 1'b1;
                        end
                        OP_CLAC: w_aluop = 3'b011;
                        OP_AND:  w_aluop = 3'b100;
                        OP_OR:   w_aluop = 3'b101;
                        OP_XOR:  w_aluop = 3'b110;
                        OP_NOT:  w_aluop = 3'b111;
                        default: ;
                    endcase
                end
                S_ADRH: begin
                    w_pcmux = 2'b01;
                    // A not-taken conditional jump skips its operand without reloading adrH/adrL.
                    w_ah    = !(((w_instr == OP_JMPZ) && !r_z) ||
                                ((w_instr == OP_JPNZ) &&  r_z));
                end
                S_ADRL: begin
                    if (w_is_mem) begin
                        w_al    = 1'b1;
                        w_pcmux = 2'b01;
                    end else if (w_jump_taken) begin
                        w_al    = 1'b1;
                        w_pcmux = 2'b10;
                    end else begin
                        w_pcmux = 2'b01;
                    end
                end
                S_MEM: begin
                    w_adr = 1'b1;
                    if (w_instr == OP_LDAC)
                        w_acmux = 2'b01;
                    else if (w_instr == OP_STAC)
                        w_we = 1'b1;
                end
                S_HALT:  w_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign io_bus.weCU      = w_we;
    assign io_bus.buffIRCU  = w_ir;
    assign io_bus.buffAHCU  = w_ah;
    assign io_bus.buffALCU  = w_al;
    assign io_bus.buffRCU   = w_r;
    assign io_bus.srcbmuxCU = w_srcb;
    assign io_bus.adrmuxCU  = w_adr;
    assign io_bus.acmuxCU   = w_acmux;
    assign io_bus.pcmuxCU   = w_pcmux;
    assign io_bus.aluopCU   = w_aluop;
    assign io_bus.halted    = w_halted;
endmodule

// File: tb/tb_cpu_controller.sv
// Testbench for cpu_controller: a small behavioural datapath and memory run
// directed programs; controller outputs and datapath state are checked.
module tb_cpu_controller;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cpu_controller_if bus ();
    cpu_controller dut (.clk(clk), .reset(reset), .io_bus(bus));

    // Datapath model.
    logic [7:0]  mem [65536];
    logic [15:0] dp_pc;
    logic [7:0]  dp_ir, dp_ah, dp_al, dp_ac, dp_r;
    logic [15:0] w_addr;
    logic [7:0]  w_mdata, w_b, w_alu, w_ah_eff, w_al_eff;
    logic [13:0] w_vec;

    assign w_addr   = bus.adrmuxCU ? {dp_ah, dp_al} : dp_pc;
    assign w_mdata  = mem[w_addr];
    assign w_ah_eff = bus.buffAHCU ? w_mdata : dp_ah;
    assign w_al_eff = bus.buffALCU ? w_mdata : dp_al;
    assign w_b      = bus.srcbmuxCU ? 8'h01 : dp_r;
    assign bus.instrCU = dp_ir;
    assign bus.zeroCU  = (w_alu == 8'h00);
    assign w_vec = {bus.weCU, bus.buffIRCU, bus.buffAHCU, bus.buffALCU, bus.buffRCU,
                    bus.srcbmuxCU, bus.adrmuxCU, bus.acmuxCU, bus.pcmuxCU, bus.aluopCU};

    always_comb begin
        case (bus.aluopCU)
            3'b000:  w_alu = dp_ac;
            3'b001:  w_alu = dp_ac + w_b;
            3'b010:  w_alu = dp_ac - w_b;
            3'b011:  w_alu = 8'h00;
            3'b100:  w_alu = dp_ac & w_b;
            3'b101:  w_alu = dp_ac | w_b;
            3'b110:  w_alu = dp_ac ^ w_b;
            default: w_alu = ~dp_ac;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            dp_pc <= 16'h0000;
            dp_ir <= 8'h00;
            dp_ah <= 8'hA5;
            dp_al <= 8'h5A;
            dp_ac <= 8'h00;
            dp_r  <= 8'h00;
        end else begin
            if (bus.buffIRCU) dp_ir <= w_mdata;
            if (bus.buffAHCU) dp_ah <= w_mdata;
            if (bus.buffALCU) dp_al <= w_mdata;
            if (bus.buffRCU)  dp_r  <= dp_ac;
            case (bus.pcmuxCU)
                2'b01:   dp_pc <= dp_pc + 16'h0001;
                2'b10:   dp_pc <= {w_ah_eff, w_al_eff};
                default: ;
            endcase
            case (bus.acmuxCU)
                2'b00:   dp_ac <= w_alu;
                2'b01:   dp_ac <= w_mdata;
                2'b10:   dp_ac <= dp_r;
                default: ;
            endcase
            if (bus.weCU) mem[w_addr] = dp_ac;
        end
    end

    localparam logic [13:0] V_IDLE  = 14'b00000000000000;
    localparam logic [13:0] V_FETCH = 14'b01000000001000;

    function automatic logic [13:0] dec_vec(input logic r, input logic srcb,
                                            input logic [1:0] ac, input logic [2:0] alu);
        return {4'b0000, r, srcb, 1'b0, ac, 2'b00, alu};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        mem[0] = 8'h0A;
        reset = 1'b1;
        step(2);
        n_cmp++; if (w_vec !== V_IDLE || bus.halted !== 1'b0) begin n_bad++;
            $display("FAIL reset_idle: got vec=%b halted=%b want vec=%b halted=0", w_vec, bus.halted, V_IDLE); end
        reset = 1'b0;
        #1;
        n_cmp++; if (w_vec !== V_FETCH) begin n_bad++;
            $display("FAIL first_fetch: got %b want %b", w_vec, V_FETCH); end
        step(1);
        n_cmp++; if (w_vec !== dec_vec(1'b0, 1'b1, 2'b00, 3'b001)) begin n_bad++;
            $display("FAIL inac_decode: got %b want %b", w_vec, dec_vec(1'b0, 1'b1, 2'b00, 3'b001)); end
        step(1);
        n_cmp++; if (dp_ac !== 8'h01 || dp_pc !== 16'h0001 || w_vec !== V_FETCH) begin n_bad++;
            $display("FAIL inac_result: got ac=%h pc=%h vec=%b want ac=01 pc=0001 vec=%b",
                     dp_ac, dp_pc, w_vec, V_FETCH); end
    endtask

    task automatic test_decode_table();
        logic [7:0]  ops  [14] = '{8'h00, 8'h03, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B,
                                   8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h01, 8'h10, 8'hFF};
        logic [13:0] exps [14];
        exps[0]  = V_IDLE;
        exps[1]  = dec_vec(1'b1, 1'b0, 2'b00, 3'b000);
        exps[2]  = dec_vec(1'b0, 1'b0, 2'b10, 3'b000);
        exps[3]  = dec_vec(1'b0, 1'b0, 2'b00, 3'b001);
        exps[4]  = dec_vec(1'b0, 1'b0, 2'b00, 3'b010);
        exps[5]  = dec_vec(1'b0, 1'b1, 2'b00, 3'b001);
        exps[6]  = dec_vec(1'b0, 1'b0, 2'b00, 3'b011);
        exps[7]  = dec_vec(1'b0, 1'b0, 2'b00, 3'b100);
        exps[8]  = dec_vec(1'b0, 1'b0, 2'b00, 3'b101);
        exps[9]  = dec_vec(1'b0, 1'b0, 2'b00, 3'b110);
        exps[10] = dec_vec(1'b0, 1'b0, 2'b00, 3'b111);
        exps[11] = V_IDLE;
        exps[12] = V_IDLE;
        exps[13] = V_IDLE;
        for (int i = 0; i < 14; i++) begin
            mem[0] = ops[i];
            apply_reset();
            step(1);
            n_cmp++; if (w_vec !== exps[i]) begin n_bad++;
                $display("FAIL decode_op_%h: got %b want %b", ops[i], w_vec, exps[i]); end
        end
    endtask

    task automatic test_load_store();
        int         we_cnt = 0;
        logic [15:0] we_addr = 16'h0000;
        logic [7:0]  we_data = 8'h00;
        int         we_cyc = -1;
        mem[0] = 8'h01; mem[1] = 8'h12; mem[2] = 8'h34;
        mem[3] = 8'h02; mem[4] = 8'h20; mem[5] = 8'h00;
        mem[16'h1234] = 8'h5A;
        mem[16'h2000] = 8'h00;
        apply_reset();
        step(5);
        n_cmp++; if (dp_ac !== 8'h5A || dp_pc !== 16'h0003) begin n_bad++;
            $display("FAIL ldac: got ac=%h pc=%h want ac=5a pc=0003", dp_ac, dp_pc); end
        for (int i = 0; i < 5; i++) begin
            if (bus.weCU === 1'b1) begin
                we_cnt++; we_addr = w_addr; we_data = dp_ac; we_cyc = i;
            end
            step(1);
        end
        n_cmp++; if (we_cnt != 1 || we_cyc != 4) begin n_bad++;
            $display("FAIL stac_we: got %0d pulses at cycle %0d want 1 pulse at cycle 4", we_cnt, we_cyc); end
        n_cmp++; if (we_addr !== 16'h2000 || we_data !== 8'h5A) begin n_bad++;
            $display("FAIL stac_bus: got addr=%h data=%h want addr=2000 data=5a", we_addr, we_data); end
        n_cmp++; if (dp_pc !== 16'h0006 || mem[16'h2000] !== 8'h5A) begin n_bad++;
            $display("FAIL stac_end: got pc=%h mem=%h want pc=0006 mem=5a", dp_pc, mem[16'h2000]); end
    endtask

    task automatic test_cond_jumps();
        logic [7:0] pre [4] = '{8'h0B, 8'h0A, 8'h0B, 8'h0A};
        logic [7:0] jop [4] = '{8'h06, 8'h06, 8'h07, 8'h07};
        logic       tkn [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] exp_pc;
        logic [7:0]  exp_ah, exp_al;
        for (int i = 0; i < 4; i++) begin
            mem[0] = pre[i]; mem[1] = jop[i]; mem[2] = 8'h12; mem[3] = 8'h40;
            apply_reset();
            step(2);
            step(4);
            exp_pc = tkn[i] ? 16'h1240 : 16'h0004;
            exp_ah = tkn[i] ? 8'h12 : 8'hA5;
            exp_al = tkn[i] ? 8'h40 : 8'h5A;
            n_cmp++; if (dp_pc !== exp_pc || dp_ah !== exp_ah || dp_al !== exp_al) begin n_bad++;
                $display("FAIL jump_%0d op=%h: got pc=%h ah=%h al=%h want pc=%h ah=%h al=%h",
                         i, jop[i], dp_pc, dp_ah, dp_al, exp_pc, exp_ah, exp_al); end
        end
        // CLAC sets Z; LDAC of a nonzero byte must leave it set.
        mem[0] = 8'h0B; mem[1] = 8'h01; mem[2] = 8'h30; mem[3] = 8'h00;
        mem[4] = 8'h06; mem[5] = 8'h12; mem[6] = 8'h40;
        mem[16'h3000] = 8'h77;
        apply_reset();
        step(11);
        n_cmp++; if (dp_pc !== 16'h1240 || dp_ac !== 8'h77) begin n_bad++;
            $display("FAIL z_hold_ldac: got pc=%h ac=%h want pc=1240 ac=77", dp_pc, dp_ac); end
    endtask

    task automatic test_logic_ops();
        logic [7:0] prog [14] = '{8'h0A, 8'h03, 8'h0A, 8'h08, 8'h03, 8'h0E, 8'h06,
                                  8'h00, 8'h09, 8'h0F, 8'h07, 8'h00, 8'h0D, 8'h04};
        for (int i = 0; i < 14; i++) mem[i] = prog[i];
        apply_reset();
        step(8);
        n_cmp++; if (dp_ac !== 8'h03 || dp_r !== 8'h01) begin n_bad++;
            $display("FAIL add_r: got ac=%h r=%h want ac=03 r=01", dp_ac, dp_r); end
        step(4);
        n_cmp++; if (dp_ac !== 8'h00 || dp_r !== 8'h03) begin n_bad++;
            $display("FAIL xor: got ac=%h r=%h want ac=00 r=03", dp_ac, dp_r); end
        step(4);
        n_cmp++; if (dp_pc !== 16'h0009 || dp_ah !== 8'h00 || dp_al !== 8'h09) begin n_bad++;
            $display("FAIL xor_z_set: got pc=%h ah=%h al=%h want pc=0009 ah=00 al=09", dp_pc, dp_ah, dp_al); end
        step(2);
        n_cmp++; if (dp_ac !== 8'hFF) begin n_bad++;
            $display("FAIL not: got ac=%h want ff", dp_ac); end
        step(4);
        n_cmp++; if (dp_pc !== 16'h000D || dp_al !== 8'h0D) begin n_bad++;
            $display("FAIL not_z_clear: got pc=%h al=%h want pc=000d al=0d", dp_pc, dp_al); end
        step(2);
        n_cmp++; if (dp_ac !== 8'h03 || dp_pc !== 16'h000E) begin n_bad++;
            $display("FAIL movr: got ac=%h pc=%h want ac=03 pc=000e", dp_ac, dp_pc); end
    endtask

    task automatic test_mid_reset();
        mem[0] = 8'h0A; mem[1] = 8'h02; mem[2] = 8'h20; mem[3] = 8'h00;
        mem[16'h2000] = 8'hEE;
        apply_reset();
        step(6);
        n_cmp++; if (bus.weCU !== 1'b1) begin n_bad++;
            $display("FAIL stac_mem_state: got we=%b want 1", bus.weCU); end
        reset = 1'b1;
        #1;
        n_cmp++; if (w_vec !== V_IDLE) begin n_bad++;
            $display("FAIL reset_in_mem: got %b want %b", w_vec, V_IDLE); end
        step(1);
        reset = 1'b0;
        #1;
        n_cmp++; if (mem[16'h2000] !== 8'hEE) begin n_bad++;
            $display("FAIL aborted_write: got mem=%h want ee", mem[16'h2000]); end
        n_cmp++; if (w_vec !== V_FETCH || dp_pc !== 16'h0000) begin n_bad++;
            $display("FAIL fetch_after_abort: got vec=%b pc=%h want vec=%b pc=0000", w_vec, dp_pc, V_FETCH); end
    endtask

    task automatic test_halt();
        int bad = 0;
        mem[0] = 8'hFF;
        apply_reset();
        step(2);
        n_cmp++; if (bus.halted !== 1'b1) begin n_bad++;
            $display("FAIL halt_enter: got halted=%b want 1", bus.halted); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_cmp++; if (bus.halted !== 1'b1 || w_vec !== V_IDLE || dp_pc !== 16'h0001) begin
                n_bad++; bad++;
                if (bad < 4)
                    $display("FAIL halt_hold_%0d: got halted=%b vec=%b pc=%h want halted=1 vec=%b pc=0001",
                             i, bus.halted, w_vec, dp_pc, V_IDLE);
            end
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.halted !== 1'b0) begin n_bad++;
            $display("FAIL halt_reset: got halted=%b want 0", bus.halted); end
        step(2);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_undefined();
        mem[0] = 8'h0A; mem[1] = 8'h10;
        apply_reset();
        step(3);
        n_cmp++; if (w_vec !== V_IDLE || dp_ir !== 8'h10) begin n_bad++;
            $display("FAIL undef_decode: got vec=%b ir=%h want vec=%b ir=10", w_vec, dp_ir, V_IDLE); end
        step(1);
        n_cmp++; if (dp_ac !== 8'h01 || dp_pc !== 16'h0002 || w_vec !== V_FETCH) begin n_bad++;
            $display("FAIL undef_nop: got ac=%h pc=%h vec=%b want ac=01 pc=0002 vec=%b",
                     dp_ac, dp_pc, w_vec, V_FETCH); end
    endtask

    initial begin
        reset = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        @(negedge clk);
        test_reset();
        test_decode_table();
        test_load_store();
        test_cond_jumps();
        test_logic_ops();
        test_mid_reset();
        test_halt();
        test_undefined();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
